// File: rtl/timer_pkg.sv
// timer_pkg: register offsets and TCON bit positions shared by the timer blocks.
package timer_pkg;
  localparam logic [31:0] TH_OFF = 32'h0;
  localparam logic [31:0] TL_OFF = 32'h4;
  localparam logic [31:0] TCON_OFF = 32'h8;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;
  localparam int TCON_OS = 3;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides sysclk into count ticks; holds while frozen, clears when stopped.
module timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic sysclk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  logic [CW-1:0] cnt;
  assign tick = run && cnt == LAST;
  always_ff @(posedge sysclk or posedge reset)
    if (reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: memory-mapped system timer with TH reload, TL count and TCON control/status.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int PRESCALE = 1
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wen,
  input  logic        ren,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        hold,
  output logic        irq
);
  logic [31:0] th, tl, word;
  logic [3:0] tcon, tcon_n;
  logic hit_th, hit_tl, hit_tc, wr_th, wr_tl, wr_tc, run, tick, ovf;
  assign word = addr & 32'hFFFF_FFFC;
  assign hit_th = word == BASE_ADDR + TH_OFF;
  assign hit_tl = word == BASE_ADDR + TL_OFF;
  assign hit_tc = word == BASE_ADDR + TCON_OFF;
  assign wr_th = wen & hit_th;
  assign wr_tl = wen & hit_tl;
  assign wr_tc = wen & hit_tc;
  assign run = tcon[TCON_EN] & ~hold;
  assign ovf = tick & (tl == 32'hFFFF_FFFF);
  assign irq = tcon[TCON_ST] & tcon[TCON_IE];
  timer_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .sysclk(sysclk),
    .reset(reset),
    .run(run),
    .clear(~tcon[TCON_EN] | wr_tl),
    .tick(tick)
  );
  // Hardware status set and oneshot stop take priority over a same-edge software write.
  always_comb begin
    tcon_n = tcon;
    if (wr_tc) tcon_n = {wdata[TCON_OS], tcon[TCON_ST] & wdata[TCON_ST], wdata[TCON_IE], wdata[TCON_EN]};
    if (ovf && tcon[TCON_IE]) tcon_n[TCON_ST] = 1'b1;
    if (ovf && tcon[TCON_OS]) tcon_n[TCON_EN] = 1'b0;
  end
  always_ff @(posedge sysclk or posedge reset)
    if (reset) begin
      th <= '0;
      tl <= '0;
      tcon <= '0;
    end else begin
      if (wr_th) th <= wdata;
      if (wr_tl) tl <= wdata;
      else if (tick) tl <= ovf ? th : tl + 32'd1;
      tcon <= tcon_n;
    end
  always_comb
    rdata = !ren ? 32'h0 : hit_th ? th : hit_tl ? tl : hit_tc ? {28'h0, tcon} : 32'h0;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed checks of timer_ctrl at PRESCALE=1 and PRESCALE=4.
module tb_timer_ctrl;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH = BASE;
  localparam logic [31:0] A_TL = BASE + 32'h4;
  localparam logic [31:0] A_TC = BASE + 32'h8;
  logic sysclk = 1'b0, reset = 1'b1, wen = 1'b0, ren = 1'b0, hold = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata1, rdata4;
  logic irq1, irq4;
  int checks = 0, failures = 0;
  timer_ctrl #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
    .sysclk(sysclk), .reset(reset), .addr(addr), .wen(wen), .ren(ren),
    .wdata(wdata), .rdata(rdata1), .hold(hold), .irq(irq1)
  );
  timer_ctrl #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
    .sysclk(sysclk), .reset(reset), .addr(addr), .wen(wen), .ren(ren),
    .wdata(wdata), .rdata(rdata4), .hold(hold), .irq(irq4)
  );
  always #10 sysclk = ~sysclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    wen = 1'b1;
    @(posedge sysclk);
    #1;
    wen = 1'b0;
  endtask
  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp, input bit four);
    addr = a;
    ren = 1'b1;
    #1;
    chk(tag, four ? rdata4 : rdata1, exp);
    ren = 1'b0;
  endtask
  initial begin
    step(2);
    chk("rst_rdata", rdata1, 32'h0);
    chk("rst_irq", irq1, 32'h0);
    chk_rd("rst_th", A_TH, 32'h0, 0);
    chk_rd("rst_tl", A_TL, 32'h0, 0);
    chk_rd("rst_tcon", A_TC, 32'h0, 0);
    reset = 1'b0;
    step(1);
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TC, 32'h3);
    chk_rd("t1_tl_start", A_TL, 32'hFFFF_FFFE, 0);
    chk("t1_irq_low", irq1, 32'h0);
    step(1);
    chk_rd("t1_tl_max", A_TL, 32'hFFFF_FFFF, 0);
    chk("t1_irq_pre", irq1, 32'h0);
    step(1);
    chk_rd("t1_reload", A_TL, 32'hFFFF_FFFC, 0);
    chk("t1_irq", irq1, 32'h1);
    step(4);
    chk_rd("t1_period", A_TL, 32'hFFFF_FFFC, 0);
    wr(A_TC, 32'h3);
    chk("t2_irq_clr", irq1, 32'h0);
    chk_rd("t2_tl_runs", A_TL, 32'hFFFF_FFFD, 0);
    chk_rd("t2_tcon", A_TC, 32'h3, 0);
    step(3);
    chk("t2_irq_again", irq1, 32'h1);
    wr(A_TC, 32'h5);
    chk("mask_irq", irq1, 32'h0);
    chk_rd("mask_keep_st", A_TC, 32'h5, 0);
    wr(A_TC, 32'h7);
    chk("unmask_irq", irq1, 32'h1);
    wr(A_TC, 32'h0);
    wr(A_TH, 32'h100);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'hB);
    chk_rd("t3_tl_max", A_TL, 32'hFFFF_FFFF, 0);
    step(1);
    chk_rd("t3_reload", A_TL, 32'h100, 0);
    chk_rd("t3_tcon", A_TC, 32'hE, 0);
    chk("t3_irq", irq1, 32'h1);
    step(3);
    chk_rd("t3_static", A_TL, 32'h100, 0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'h3);
    chk("th_race_irq0", irq1, 32'h0);
    wr(A_TH, 32'h200);
    chk_rd("th_race_old", A_TL, 32'h100, 0);
    chk_rd("th_race_new", A_TH, 32'h200, 0);
    chk("th_race_irq", irq1, 32'h1);
    wr(A_TL, 32'h10);
    chk_rd("t5_tl_wins", A_TL, 32'h10, 0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'h3);
    chk_rd("t5_hw_wins", A_TC, 32'h7, 0);
    chk_rd("t5_reload", A_TL, 32'h200, 0);
    addr = A_TL;
    wdata = 32'h55;
    wen = 1'b1;
    ren = 1'b1;
    #1;
    chk("rw_pre", rdata1, 32'h200);
    @(posedge sysclk);
    #1;
    wen = 1'b0;
    ren = 1'b0;
    chk_rd("rw_post", A_TL, 32'h55, 0);
    wr(BASE + 32'hC, 32'hFFFF_FFFF);
    wr(32'h5000_0004, 32'h77);
    chk_rd("miss_no_write", A_TL, 32'h57, 0);
    chk_rd("miss_hi_rd", 32'h5000_0004, 32'h0, 0);
    chk_rd("miss_off_rd", BASE + 32'hC, 32'h0, 0);
    addr = A_TL;
    #1;
    chk("no_ren", rdata1, 32'h0);
    wr(A_TC, 32'hFFFF_FFF3);
    chk_rd("tcon_upper", A_TC, 32'h3, 0);
    wr(A_TL, 32'hFFFF_FFFF);
    step(1);
    chk("t6_irq_pre", irq1, 32'h1);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_irq", irq1, 32'h0);
    chk_rd("t6_th", A_TH, 32'h0, 0);
    chk_rd("t6_tl", A_TL, 32'h0, 0);
    chk_rd("t6_tcon", A_TC, 32'h0, 0);
    reset = 1'b0;
    step(1);
    wr(A_TL, 32'h0);
    wr(A_TC, 32'h1);
    step(3);
    chk_rd("t4_before", A_TL, 32'h0, 1);
    step(1);
    chk_rd("t4_first", A_TL, 32'h1, 1);
    step(2);
    hold = 1'b1;
    step(3);
    chk_rd("t4_frozen", A_TL, 32'h1, 1);
    hold = 1'b0;
    step(1);
    chk_rd("t4_not_yet", A_TL, 32'h1, 1);
    step(1);
    chk_rd("t4_delayed", A_TL, 32'h2, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
